// File: rtl/bist_pkg.sv
// Shared types and constants for the BIST engine and its signature analyser.
// Latency: n/a (types, constants and one pure decode function).
// Backpressure: n/a.
package bist_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        GEN,
        DRAIN,
        DONE
    } bist_state_e;

    typedef enum logic [1:0] {
        PAT_LFSR,
        PAT_COUNT,
        PAT_EXT
    } bist_pat_e;

    // Default feedback masks per data width.
    localparam logic [7:0]  TAPS_W8  = 8'hB8;
    localparam logic [63:0] TAPS_W64 = 64'hD800_0000_0000_0000;

    // Raw mode field -> pattern source; the unused encoding 3 behaves as LFSR.
    function automatic bist_pat_e decode_pat(input logic [1:0] mode);
        case (mode)
            2'd1:    return PAT_COUNT;
            2'd2:    return PAT_EXT;
            default: return PAT_LFSR;
        endcase
    endfunction

endpackage

// File: rtl/bist_misr.sv
// Multiple-input signature register: shift with parity feedback, XOR in data.
// Latency: a compressed word shows on sig_o one cycle after comp_i.
// Backpressure: none; en_i freezes the register, load_i has priority over comp_i.
// Ports: clk_i/rst_i (sync, active high), en_i, load_i + load_val_i,
//        comp_i + data_i, sig_o (current signature).
module bist_misr
    import bist_pkg::*;
#(
    parameter int                DATA_W = 64,
    parameter logic [DATA_W-1:0] TAPS   = DATA_W'(TAPS_W64)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              load_i,
    input  logic [DATA_W-1:0] load_val_i,
    input  logic              comp_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] sig_o
);

    logic [DATA_W-1:0] sig_q, sig_d;

    always_comb begin
        sig_d = sig_q;
        if (en_i) begin
            if (load_i) begin
                sig_d = load_val_i;
            end else if (comp_i) begin
                sig_d = {sig_q[DATA_W-2:0], ^(sig_q & TAPS)} ^ data_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig_o = sig_q;

endmodule

// File: rtl/bist_engine.sv
// BIST engine: generates stimulus (LFSR/counter/external), compresses responses, compares signature.
// Latency: start_i in IDLE -> first dut_valid_o after 2 cycles; done_o 1 cycle after the drain window.
// Backpressure: valid/ready on dut_*; data and pattern hold while valid & !ready; en_i=0 freezes all.
// Ports: clk_i, rst_i (sync, active high), en_i, start_i/abort_i control; pat_mode_i, seed_i,
//        sig_seed_i, num_vec_i, drain_i, exp_sig_i config; ext_* external stimulus (mode 2);
//        dut_* stimulus out / response in; busy_o, done_o, pass_o, timeout_o, sig_o, vec_cnt_o status.
// Optional: define BIST_TIMEOUT_EN to end a run stalled for 2^TO_W-1 consecutive cycles.
module bist_engine
    import bist_pkg::*;
#(
    parameter int                DATA_W  = 64,
    parameter logic [DATA_W-1:0] TAPS    = DATA_W'(TAPS_W64),
    parameter int                LEN_W   = 16,
    parameter int                DRAIN_W = 8
`ifdef BIST_TIMEOUT_EN
    ,
    parameter int                TO_W    = 12
`endif
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               en_i,
    input  logic               start_i,
    input  logic               abort_i,
    input  logic [1:0]         pat_mode_i,
    input  logic [DATA_W-1:0]  seed_i,
    input  logic [DATA_W-1:0]  sig_seed_i,
    input  logic [LEN_W-1:0]   num_vec_i,
    input  logic [DRAIN_W-1:0] drain_i,
    input  logic [DATA_W-1:0]  exp_sig_i,
    input  logic               ext_valid_i,
    input  logic [DATA_W-1:0]  ext_data_i,
    output logic               ext_ready_o,
    output logic               dut_valid_o,
    output logic [DATA_W-1:0]  dut_data_o,
    input  logic               dut_ready_i,
    input  logic               dut_valid_i,
    input  logic [DATA_W-1:0]  dut_data_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               pass_o,
    output logic               timeout_o,
    output logic [DATA_W-1:0]  sig_o,
    output logic [LEN_W-1:0]   vec_cnt_o
);

    bist_state_e        state_q, state_d;
    bist_pat_e          mode_q, mode_d;
    logic [DATA_W-1:0]  pat_q, pat_d, pat_step;
    logic [LEN_W-1:0]   num_q, num_d;
    logic [LEN_W-1:0]   vec_q, vec_d, vec_inc;
    logic [DRAIN_W-1:0] dcnt_q, dcnt_d;
    logic [DRAIN_W:0]   dcnt_inc;
    logic               timeout_q, timeout_d;
    logic               in_gen, xfer;
    logic               misr_load, misr_comp;
`ifdef BIST_TIMEOUT_EN
    logic [TO_W-1:0]    to_q, to_d;
`endif

    assign in_gen      = (state_q == GEN);
    assign dut_valid_o = in_gen && ((mode_q != PAT_EXT) || ext_valid_i);
    assign xfer        = dut_valid_o && dut_ready_i;
    assign vec_inc     = vec_q + LEN_W'(1);
    // One bit wider so drain_i = all-ones still terminates.
    assign dcnt_inc    = {1'b0, dcnt_q} + (DRAIN_W + 1)'(1);

    always_comb begin
        pat_step = {pat_q[DATA_W-2:0], ^(pat_q & TAPS)};
        if (mode_q == PAT_COUNT) begin
            pat_step = pat_q + DATA_W'(1);
        end
    end

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        pat_d     = pat_q;
        num_d     = num_q;
        vec_d     = vec_q;
        dcnt_d    = dcnt_q;
        timeout_d = timeout_q;
`ifdef BIST_TIMEOUT_EN
        to_d      = to_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                mode_d    = decode_pat(pat_mode_i);
                pat_d     = seed_i;
                // An all-zero LFSR state would lock up.
                if ((mode_d == PAT_LFSR) && (seed_i == '0)) begin
                    pat_d = DATA_W'(1);
                end
                num_d     = num_vec_i;
                vec_d     = '0;
                dcnt_d    = '0;
                timeout_d = 1'b0;
`ifdef BIST_TIMEOUT_EN
                to_d      = '0;
`endif
                state_d   = (num_vec_i == '0) ? DRAIN : GEN;
            end
            GEN: begin
                if (xfer) begin
                    pat_d = pat_step;
                    vec_d = vec_inc;
                    if (vec_inc == num_q) begin
                        state_d = DRAIN;
                    end
                end
`ifdef BIST_TIMEOUT_EN
                if (dut_valid_o && !dut_ready_i) begin
                    to_d = to_q + TO_W'(1);
                    if (&to_d) begin
                        state_d   = DONE;
                        timeout_d = 1'b1;
                    end
                end else begin
                    to_d = '0;
                end
`endif
            end
            DRAIN: begin
                dcnt_d = dcnt_inc[DRAIN_W-1:0];
                // drain_i == 0 still spends one cycle here.
                if (dcnt_inc >= {1'b0, drain_i}) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!start_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (abort_i) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            mode_q    <= PAT_LFSR;
            pat_q     <= '0;
            num_q     <= '0;
            vec_q     <= '0;
            dcnt_q    <= '0;
            timeout_q <= 1'b0;
`ifdef BIST_TIMEOUT_EN
            to_q      <= '0;
`endif
        end else if (en_i) begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            pat_q     <= pat_d;
            num_q     <= num_d;
            vec_q     <= vec_d;
            dcnt_q    <= dcnt_d;
            timeout_q <= timeout_d;
`ifdef BIST_TIMEOUT_EN
            to_q      <= to_d;
`endif
        end
    end

    assign misr_load = (state_q == LOAD);
    assign misr_comp = ((state_q == GEN) || (state_q == DRAIN)) && dut_valid_i;

    bist_misr #(
        .DATA_W (DATA_W),
        .TAPS   (TAPS)
    ) u_misr (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .en_i       (en_i),
        .load_i     (misr_load),
        .load_val_i (sig_seed_i),
        .comp_i     (misr_comp),
        .data_i     (dut_data_i),
        .sig_o      (sig_o)
    );

    assign dut_data_o  = !in_gen ? '0 : ((mode_q == PAT_EXT) ? ext_data_i : pat_q);
    assign ext_ready_o = in_gen && (mode_q == PAT_EXT) && dut_ready_i;
    assign busy_o      = (state_q == LOAD) || (state_q == GEN) || (state_q == DRAIN);
    assign done_o      = (state_q == DONE);
    assign pass_o      = done_o && !timeout_q && (sig_o == exp_sig_i);
    assign vec_cnt_o   = vec_q;
`ifdef BIST_TIMEOUT_EN
    assign timeout_o   = done_o && timeout_q;
`else
    assign timeout_o   = 1'b0;
`endif

endmodule

// File: tb/tb_bist_engine.sv
// Bench for bist_engine at DATA_W=8, TAPS=8'hB8 with response loopback.
// Latency: checks first-valid and done timing cycle by cycle.
// Backpressure: drives scheduled ready stalls and external-valid gaps.
module tb_bist_engine;

    localparam int DW = 8;

    logic          clk_i = 1'b0;
    logic          rst_i, en_i, start_i, abort_i;
    logic [1:0]    pat_mode_i;
    logic [DW-1:0] seed_i, sig_seed_i, exp_sig_i, ext_data_i;
    logic [15:0]   num_vec_i;
    logic [7:0]    drain_i;
    logic          ext_valid_i, ext_ready_o, dut_valid_o, dut_ready_i, dut_valid_i;
    logic [DW-1:0] dut_data_o, dut_data_i, sig_o;
    logic          busy_o, done_o, pass_o, timeout_o;
    logic [15:0]   vec_cnt_o;

    always #5 clk_i = ~clk_i;

    // Responses loop straight back from the stimulus port.
    assign dut_valid_i = dut_valid_o;
    assign dut_data_i  = dut_data_o;

    bist_engine #(.DATA_W(DW), .TAPS(8'hB8)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .start_i(start_i), .abort_i(abort_i),
        .pat_mode_i(pat_mode_i), .seed_i(seed_i), .sig_seed_i(sig_seed_i),
        .num_vec_i(num_vec_i), .drain_i(drain_i), .exp_sig_i(exp_sig_i),
        .ext_valid_i(ext_valid_i), .ext_data_i(ext_data_i), .ext_ready_o(ext_ready_o),
        .dut_valid_o(dut_valid_o), .dut_data_o(dut_data_o), .dut_ready_i(dut_ready_i),
        .dut_valid_i(dut_valid_i), .dut_data_i(dut_data_i),
        .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .timeout_o(timeout_o),
        .sig_o(sig_o), .vec_cnt_o(vec_cnt_o)
    );

    int total = 0;
    int bad   = 0;

    int         stall_a [16];
    int         gap_a   [16];
    logic [7:0] ext_a   [16];
    logic [7:0] mvec    [16];
    logic [7:0] msig;
    logic [7:0] obs_q[$];
    logic [7:0] res_sig;
    logic       res_pass;

    typedef struct {
        logic [1:0] mode;
        logic [7:0] seed;
        logic [7:0] sseed;
        int         nv;
        int         drn;
        logic [7:0] esig;
        logic [7:0] last;
        logic [7:0] sig;
        logic       pass;
    } tv_t;
    tv_t tv [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Shift left one place, feed back the parity of the tapped bits.
    function automatic logic [7:0] step8(input logic [7:0] s);
        int v;
        v = (int'(s) * 2) % 256 + ($countones(s & 8'hB8) % 2);
        return 8'(v);
    endfunction

    // Expected vectors and signature; every cycle with valid compresses once.
    task automatic build_model(input logic [1:0] mode, input logic [7:0] seed,
                               input logic [7:0] sseed, input int nv);
        logic [7:0] p;
        p = (seed == 8'h00) ? 8'h01 : seed;
        for (int i = 0; i < nv; i++) begin
            if (mode == 2'd1)      mvec[i] = 8'((int'(seed) + i) % 256);
            else if (mode == 2'd2) mvec[i] = ext_a[i];
            else begin
                mvec[i] = p;
                p = step8(p);
            end
        end
        msig = sseed;
        for (int i = 0; i < nv; i++)
            for (int k = 0; k <= stall_a[i]; k++)
                msig = step8(msig) ^ mvec[i];
    endtask

    task automatic clear_sched();
        for (int i = 0; i < 16; i++) begin
            stall_a[i] = 0;
            gap_a[i]   = 0;
            ext_a[i]   = 8'h00;
        end
    endtask

    // One complete run; entered and left at #1 after a rising edge.
    task automatic run(input logic [1:0] mode, input logic [7:0] seed, input logic [7:0] sseed,
                       input int nv, input int drn, input logic [7:0] esig);
        int d_cyc;
        d_cyc = (drn == 0) ? 1 : drn;
        obs_q.delete();
        pat_mode_i = mode; seed_i = seed; sig_seed_i = sseed;
        num_vec_i = 16'(nv); drain_i = 8'(drn); exp_sig_i = esig;
        dut_ready_i = 1'b1; ext_valid_i = 1'b0; start_i = 1'b1;
        @(posedge clk_i); #1;
        @(negedge clk_i);
        check("load_busy", busy_o, 1);
        check("load_valid", dut_valid_o, 0);
        @(posedge clk_i); #1;
        for (int i = 0; i < nv; i++) begin
            ext_data_i = ext_a[i];
            for (int k = 0; k < gap_a[i]; k++) begin
                ext_valid_i = 1'b0;
                dut_ready_i = 1'($urandom_range(0, 1));
                @(negedge clk_i);
                check("gap_valid", dut_valid_o, 0);
                check("gap_cnt", vec_cnt_o, i);
                @(posedge clk_i); #1;
            end
            ext_valid_i = 1'b1;
            for (int k = 0; k <= stall_a[i]; k++) begin
                dut_ready_i = (k == stall_a[i]);
                @(negedge clk_i);
                check("gen_valid", dut_valid_o, 1);
                check("gen_cnt", vec_cnt_o, i);
                check("gen_data", dut_data_o, mvec[i]);
                check("ext_ready", ext_ready_o, (mode == 2'd2) && dut_ready_i);
                if (dut_ready_i) obs_q.push_back(dut_data_o);
                @(posedge clk_i); #1;
            end
        end
        ext_valid_i = 1'b0; dut_ready_i = 1'b1;
        for (int k = 0; k < d_cyc; k++) begin
            @(negedge clk_i);
            check("drain_done", done_o, 0);
            check("drain_busy", busy_o, 1);
            @(posedge clk_i); #1;
        end
        @(negedge clk_i);
        check("done", done_o, 1);
        check("done_busy", busy_o, 0);
        check("final_cnt", vec_cnt_o, nv);
        check("timeout", timeout_o, 0);
        res_sig  = sig_o;
        res_pass = pass_o;
        @(posedge clk_i); #1;
        @(negedge clk_i);
        check("done_hold", done_o, 1);
        check("sig_hold", sig_o, msig);
        start_i = 1'b0;
        @(posedge clk_i); #1;
        @(negedge clk_i);
        check("idle_done", done_o, 0);
        check("idle_pass", pass_o, 0);
        @(posedge clk_i); #1;
    endtask

    logic [1:0] r_mode;
    logic [7:0] r_seed, r_sseed, r_esig, fsig;
    int         r_nv, r_drn;

    initial begin
        rst_i = 1'b1; en_i = 1'b1; start_i = 1'b0; abort_i = 1'b0;
        pat_mode_i = 2'd0; seed_i = '0; sig_seed_i = '0; num_vec_i = '0; drain_i = '0;
        exp_sig_i = '0; ext_valid_i = 1'b0; ext_data_i = '0; dut_ready_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        @(negedge clk_i);
        check("rst_valid", dut_valid_o, 0);
        check("rst_data", dut_data_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_pass", pass_o, 0);
        check("rst_timeout", timeout_o, 0);
        check("rst_sig", sig_o, 0);
        check("rst_cnt", vec_cnt_o, 0);
        check("rst_ext_rdy", ext_ready_o, 0);
        rst_i = 1'b0;
        @(posedge clk_i); #1;

        //        mode   seed   sseed  nv drn esig   last   sig    pass
        tv[0] = '{2'd0, 8'h01, 8'h00, 5, 1, 8'h11, 8'h11, 8'h11, 1'b1};
        tv[1] = '{2'd0, 8'h00, 8'h00, 5, 0, 8'h00, 8'h11, 8'h11, 1'b0};
        tv[2] = '{2'd1, 8'h10, 8'h00, 4, 2, 8'hF7, 8'h13, 8'hF7, 1'b1};
        tv[3] = '{2'd1, 8'h10, 8'h00, 4, 2, 8'hF6, 8'h13, 8'hF7, 1'b0};
        tv[4] = '{2'd1, 8'h10, 8'h5A, 0, 0, 8'h5A, 8'h00, 8'h5A, 1'b1};
        tv[5] = '{2'd3, 8'h01, 8'h00, 5, 3, 8'h00, 8'h11, 8'h11, 1'b0};
        tv[6] = '{2'd1, 8'hFE, 8'h00, 3, 1, 8'h06, 8'h00, 8'h06, 1'b1};
        for (int t = 0; t < 7; t++) begin
            clear_sched();
            build_model(tv[t].mode, tv[t].seed, tv[t].sseed, tv[t].nv);
            run(tv[t].mode, tv[t].seed, tv[t].sseed, tv[t].nv, tv[t].drn, tv[t].esig);
            check("tv_nvec", obs_q.size(), tv[t].nv);
            if (tv[t].nv > 0 && obs_q.size() > 0) check("tv_last", obs_q[obs_q.size()-1], tv[t].last);
            check("tv_sig", res_sig, tv[t].sig);
            check("tv_pass", res_pass, tv[t].pass);
        end

        // Counter run with ready low for 3 cycles on the third vector.
        clear_sched();
        stall_a[2] = 3;
        build_model(2'd1, 8'h10, 8'h00, 4);
        run(2'd1, 8'h10, 8'h00, 4, 2, msig);
        check("stall_nvec", obs_q.size(), 4);
        for (int i = 0; i < 4 && i < obs_q.size(); i++) check("stall_vec", obs_q[i], 8'h10 + 8'(i));
        check("stall_sig", res_sig, msig);
        check("stall_pass", res_pass, 1);

        // Randomised runs against the reference model.
        for (int r = 0; r < 12; r++) begin
            r_mode  = 2'($urandom_range(0, 3));
            r_nv    = $urandom_range(0, 6);
            r_drn   = $urandom_range(0, 3);
            r_seed  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            r_sseed = 8'($urandom);
            for (int i = 0; i < 16; i++) begin
                stall_a[i] = $urandom_range(0, 2);
                gap_a[i]   = (r_mode == 2'd2) ? $urandom_range(0, 2) : 0;
                ext_a[i]   = 8'($urandom);
            end
            build_model(r_mode, r_seed, r_sseed, r_nv);
            r_esig = ($urandom_range(0, 1) == 1) ? msig : (msig ^ 8'h01);
            run(r_mode, r_seed, r_sseed, r_nv, r_drn, r_esig);
            check("rnd_nvec", obs_q.size(), r_nv);
            for (int i = 0; i < r_nv && i < obs_q.size(); i++) check("rnd_vec", obs_q[i], mvec[i]);
            check("rnd_sig", res_sig, msig);
            check("rnd_pass", res_pass, r_esig == msig);
        end

        // Clock-enable freeze, then abort (with start still high) during GEN.
        clear_sched();
        build_model(2'd1, 8'h20, 8'h00, 10);
        fsig = 8'h00;
        for (int i = 0; i < 2; i++) fsig = step8(fsig) ^ mvec[i];
        pat_mode_i = 2'd1; seed_i = 8'h20; sig_seed_i = 8'h00; num_vec_i = 16'd10;
        drain_i = 8'd0; dut_ready_i = 1'b1; start_i = 1'b1;
        repeat (4) @(posedge clk_i);
        #1;
        en_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk_i);
            check("frz_cnt", vec_cnt_o, 2);
            check("frz_data", dut_data_o, 8'h22);
            check("frz_sig", sig_o, fsig);
            @(posedge clk_i); #1;
        end
        en_i = 1'b1; abort_i = 1'b1;
        @(posedge clk_i); #1;
        abort_i = 1'b0; start_i = 1'b0;
        @(negedge clk_i);
        check("abort_busy", busy_o, 0);
        check("abort_valid", dut_valid_o, 0);
        check("abort_done", done_o, 0);
        @(posedge clk_i); #1;
        @(negedge clk_i);
        check("abort_idle", busy_o, 0);
        @(posedge clk_i); #1;

        // Reset in the middle of GEN.
        start_i = 1'b1;
        repeat (4) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0; start_i = 1'b0;
        @(negedge clk_i);
        check("mrst_busy", busy_o, 0);
        check("mrst_valid", dut_valid_o, 0);
        check("mrst_sig", sig_o, 0);
        check("mrst_cnt", vec_cnt_o, 0);
        check("mrst_done", done_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
